// File: rtl/tlp_compl_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tlp_compl_arbiter_pkg
// Shared definitions for the completion arbiter: completion header field
// widths, completion status codes, the arbiter state type, the packed
// completion header record and a saturating counter helper.
// -----------------------------------------------------------------------------
package tlp_compl_arbiter_pkg;

  // Completion header field widths
  localparam int TC_W   = 3;
  localparam int ATTR_W = 2;
  localparam int LEN_W  = 10;
  localparam int RID_W  = 16;
  localparam int TAG_W  = 8;
  localparam int BE_W   = 8;
  localparam int ADDR_W = 7;
  localparam int CODE_W = 3;

  // Completion status codes
  localparam logic [CODE_W-1:0] CPL_SC = 3'b000;  // successful completion
  localparam logic [CODE_W-1:0] CPL_UR = 3'b001;  // unsupported request
  localparam logic [CODE_W-1:0] CPL_CA = 3'b100;  // completer abort

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [TC_W-1:0]   tc;
    logic [ATTR_W-1:0] attr;
    logic [LEN_W-1:0]  len;
    logic [RID_W-1:0]  rid;
    logic [TAG_W-1:0]  tag;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [CODE_W-1:0] code;
  } cpl_hdr_t;

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tlp_compl_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the request vector starting at the
// position after i_ptr (the last winner) and wrapping modulo N.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index of the previous winner
//   o_gnt   : one-hot winner (all zero when no request)
//   o_idx   : binary index of the winner
//   o_valid : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);

  localparam int PW = $clog2(N);

  int            w_cand;
  logic [PW-1:0] w_cidx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    w_cidx  = '0;
    // Offsets 1..N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      w_cidx = PW'(w_cand);
      if (!o_valid && i_req[w_cidx]) begin
        o_valid       = 1'b1;
        o_gnt[w_cidx] = 1'b1;
        o_idx         = w_cidx;
      end
    end
  end

endmodule

// File: rtl/tlp_compl_arbiter.sv
// -----------------------------------------------------------------------------
// tlp_compl_arbiter
// Shares the single completion path of the TLP encoder between NUM_REQ
// completion sources. Round-robin grant in IDLE, latched header offered to the
// encoder in OFFER with a valid/ready handshake. Also handles the power-
// management turn-off acknowledge and discards offers on link-down/timeout.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   rq_req   [N]          per-requester request level (held until granted)
//   rq_gnt   [N]          one-hot combinational grant; header taken at edge
//   rq_tc/attr/len/rid/tag/be/addr/code  packed headers, slice i = requester i
//   req_compl             offer valid to encoder
//   tlp_encoder_ready     encoder accept
//   tenc_* / compl_code   registered header of the current offer
//   lnk_up                link up; offers dropped and grants held while low
//   cfg_to_turnoff        turn-off request (level or pulse)
//   cfg_to_turnoff_ok     one-cycle turn-off acknowledge
//   busy                  offer in flight
//   drop_cnt  [8]         saturating count of discarded offers
// -----------------------------------------------------------------------------
module tlp_compl_arbiter
  import tlp_compl_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [NUM_REQ-1:0]        rq_req,
  output logic [NUM_REQ-1:0]        rq_gnt,
  input  logic [TC_W*NUM_REQ-1:0]   rq_tc,
  input  logic [ATTR_W*NUM_REQ-1:0] rq_attr,
  input  logic [LEN_W*NUM_REQ-1:0]  rq_len,
  input  logic [RID_W*NUM_REQ-1:0]  rq_rid,
  input  logic [TAG_W*NUM_REQ-1:0]  rq_tag,
  input  logic [BE_W*NUM_REQ-1:0]   rq_be,
  input  logic [ADDR_W*NUM_REQ-1:0] rq_addr,
  input  logic [CODE_W*NUM_REQ-1:0] rq_code,

  output logic                      req_compl,
  input  logic                      tlp_encoder_ready,
  output logic [TC_W-1:0]           tenc_tc,
  output logic [ATTR_W-1:0]         tenc_attr,
  output logic [LEN_W-1:0]          tenc_len,
  output logic [RID_W-1:0]          tenc_rid,
  output logic [TAG_W-1:0]          tenc_tag,
  output logic [BE_W-1:0]           tenc_be,
  output logic [ADDR_W-1:0]         tenc_addr,
  output logic [CODE_W-1:0]         compl_code,

  input  logic                      lnk_up,
  input  logic                      cfg_to_turnoff,
  output logic                      cfg_to_turnoff_ok,
  output logic                      busy,
  output logic [7:0]                drop_cnt
);

  localparam int PW     = $clog2(NUM_REQ);
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Last wait-count value before the offer is abandoned; the offer is visible
  // for exactly TIMEOUT cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

  arb_state_e        r_state;
  logic [PW-1:0]     r_last;
  logic              r_pending;
  logic              r_to_armed;
  logic              r_ok;
  logic [7:0]        r_drop;
  logic [WAIT_W-1:0] r_wait;
  cpl_hdr_t          r_hdr;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PW-1:0]      w_arb_idx;
  logic               w_arb_valid;
  logic               w_to_rise;
  logic               w_grant_en;
  logic               w_accept;
  logic               w_link_drop;
  logic               w_timeout;
  cpl_hdr_t           w_hdr_arr [NUM_REQ];
  cpl_hdr_t           w_hdr_sel;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .i_req   (rq_req),
    .i_ptr   (r_last),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Unpack each requester's header slices into one record per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hdr
    assign w_hdr_arr[g] = '{
      tc:   rq_tc  [g*TC_W   +: TC_W],
      attr: rq_attr[g*ATTR_W +: ATTR_W],
      len:  rq_len [g*LEN_W  +: LEN_W],
      rid:  rq_rid [g*RID_W  +: RID_W],
      tag:  rq_tag [g*TAG_W  +: TAG_W],
      be:   rq_be  [g*BE_W   +: BE_W],
      addr: rq_addr[g*ADDR_W +: ADDR_W],
      code: rq_code[g*CODE_W +: CODE_W]
    };
  end

  assign w_hdr_sel = w_hdr_arr[w_arb_idx];

  // A held-high turn-off level only counts once; it must be seen low again.
  assign w_to_rise = cfg_to_turnoff & r_to_armed;

  // Reset is included so the combinational grant is also zero while reset is
  // asserted. A turn-off arriving this cycle beats a new request.
  assign w_grant_en = reset & (r_state == ST_IDLE) & lnk_up & ~r_pending &
                      ~w_to_rise & w_arb_valid;

  assign w_accept    = (r_state == ST_OFFER) & tlp_encoder_ready;
  assign w_link_drop = (r_state == ST_OFFER) & ~lnk_up;
  assign w_timeout   = (r_state == ST_OFFER) & (TIMEOUT != 0) &
                       (r_wait == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_last     <= PW'(NUM_REQ - 1);
      r_pending  <= 1'b0;
      r_to_armed <= 1'b1;
      r_ok       <= 1'b0;
      r_drop     <= '0;
      r_wait     <= '0;
      r_hdr      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      r_ok <= 1'b0;

      if (!cfg_to_turnoff) r_to_armed <= 1'b1;
      else if (w_to_rise)  r_to_armed <= 1'b0;

      // Acknowledge once no offer is in flight; an offer accepted at this
      // edge counts as returning to IDLE.
      if (r_pending && (r_state == ST_IDLE || w_accept)) begin
        r_ok      <= 1'b1;
        r_pending <= w_to_rise;
      end else if (w_to_rise) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_hdr   <= w_hdr_sel;
            r_last  <= w_arb_idx;
            r_wait  <= '0;
            r_state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // Accept has priority over a simultaneous link-down or timeout.
          if (w_accept) begin
            r_state <= ST_IDLE;
          end else if (w_link_drop || w_timeout) begin
            r_drop  <= sat_inc8(r_drop);
            r_state <= ST_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rq_gnt            = w_grant_en ? w_arb_gnt : '0;
  assign req_compl         = (r_state == ST_OFFER);
  assign busy              = (r_state == ST_OFFER);
  assign cfg_to_turnoff_ok = r_ok;
  assign drop_cnt          = r_drop;
  assign tenc_tc           = r_hdr.tc;
  assign tenc_attr         = r_hdr.attr;
  assign tenc_len          = r_hdr.len;
  assign tenc_rid          = r_hdr.rid;
  assign tenc_tag          = r_hdr.tag;
  assign tenc_be           = r_hdr.be;
  assign tenc_addr         = r_hdr.addr;
  assign compl_code        = r_hdr.code;

endmodule

// File: tb/tb_tlp_compl_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tlp_compl_arbiter
// Directed bench for tlp_compl_arbiter (NUM_REQ=3, TIMEOUT=16). Requester i
// presents a fixed, distinct header built by the exp_* functions below.
// -----------------------------------------------------------------------------
module tb_tlp_compl_arbiter;
  import tlp_compl_arbiter_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [N-1:0] rq_req;
  logic [N-1:0] rq_gnt;
  logic [TC_W*N-1:0]   rq_tc;
  logic [ATTR_W*N-1:0] rq_attr;
  logic [LEN_W*N-1:0]  rq_len;
  logic [RID_W*N-1:0]  rq_rid;
  logic [TAG_W*N-1:0]  rq_tag;
  logic [BE_W*N-1:0]   rq_be;
  logic [ADDR_W*N-1:0] rq_addr;
  logic [CODE_W*N-1:0] rq_code;
  logic        req_compl;
  logic        tlp_encoder_ready;
  logic [2:0]  tenc_tc;
  logic [1:0]  tenc_attr;
  logic [9:0]  tenc_len;
  logic [15:0] tenc_rid;
  logic [7:0]  tenc_tag;
  logic [7:0]  tenc_be;
  logic [6:0]  tenc_addr;
  logic [2:0]  compl_code;
  logic        lnk_up;
  logic        cfg_to_turnoff;
  logic        cfg_to_turnoff_ok;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [7:0]  tag_xor;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] exp_rid(input int i);  return 16'h0100 + 16'(i);    endfunction
  function automatic logic [7:0]  exp_tag(input int i);  return 8'h05 + 8'(i * 16);   endfunction
  function automatic logic [2:0]  exp_tc(input int i);   return 3'(i + 1);           endfunction
  function automatic logic [1:0]  exp_attr(input int i); return 2'(i);               endfunction
  function automatic logic [9:0]  exp_len(input int i);  return 10'(i + 1);          endfunction
  function automatic logic [7:0]  exp_be(input int i);   return 8'hF0 | 8'(i);       endfunction
  function automatic logic [6:0]  exp_addr(input int i); return 7'(i * 4);           endfunction
  function automatic logic [2:0]  exp_code(input int i);
    return (i == 0) ? CPL_SC : (i == 1) ? CPL_UR : CPL_CA;
  endfunction

  assign rq_tc   = {exp_tc(2),   exp_tc(1),   exp_tc(0)};
  assign rq_attr = {exp_attr(2), exp_attr(1), exp_attr(0)};
  assign rq_len  = {exp_len(2),  exp_len(1),  exp_len(0)};
  assign rq_rid  = {exp_rid(2),  exp_rid(1),  exp_rid(0)};
  // tag_xor lets the bench disturb the source header after a grant.
  assign rq_tag  = {exp_tag(2) ^ tag_xor, exp_tag(1) ^ tag_xor, exp_tag(0) ^ tag_xor};
  assign rq_be   = {exp_be(2),   exp_be(1),   exp_be(0)};
  assign rq_addr = {exp_addr(2), exp_addr(1), exp_addr(0)};
  assign rq_code = {exp_code(2), exp_code(1), exp_code(0)};

  tlp_compl_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rq_req            (rq_req),
    .rq_gnt            (rq_gnt),
    .rq_tc             (rq_tc),
    .rq_attr           (rq_attr),
    .rq_len            (rq_len),
    .rq_rid            (rq_rid),
    .rq_tag            (rq_tag),
    .rq_be             (rq_be),
    .rq_addr           (rq_addr),
    .rq_code           (rq_code),
    .req_compl         (req_compl),
    .tlp_encoder_ready (tlp_encoder_ready),
    .tenc_tc           (tenc_tc),
    .tenc_attr         (tenc_attr),
    .tenc_len          (tenc_len),
    .tenc_rid          (tenc_rid),
    .tenc_tag          (tenc_tag),
    .tenc_be           (tenc_be),
    .tenc_addr         (tenc_addr),
    .compl_code        (compl_code),
    .lnk_up            (lnk_up),
    .cfg_to_turnoff    (cfg_to_turnoff),
    .cfg_to_turnoff_ok (cfg_to_turnoff_ok),
    .busy              (busy),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after changing inputs.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    rq_req            = '0;
    tlp_encoder_ready = 1'b0;
    cfg_to_turnoff    = 1'b0;
    lnk_up            = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_cycles;
    int e;

    // ---------------- reset state ----------------
    reset             = 1'b0;
    rq_req            = 3'b001;
    tlp_encoder_ready = 1'b0;
    cfg_to_turnoff    = 1'b0;
    lnk_up            = 1'b1;
    tag_xor           = 8'h00;
    #3;
    check("rst_req_compl", 32'(req_compl), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_drop",      32'(drop_cnt),  32'd0);
    check("rst_ok",        32'(cfg_to_turnoff_ok), 32'd0);
    check("rst_gnt",       32'(rq_gnt),    32'd0);
    check("rst_tag",       32'(tenc_tag),  32'd0);
    check("rst_code",      32'(compl_code), 32'd0);
    tick();
    tick();
    rq_req = '0;
    reset  = 1'b1;

    // ---------------- single request ----------------
    rq_req            = 3'b001;
    tlp_encoder_ready = 1'b1;
    settle();
    check("single_gnt",       32'(rq_gnt),    32'h1);
    check("single_rc_before", 32'(req_compl), 32'd0);
    tick();
    rq_req = '0;
    settle();
    check("single_rc",   32'(req_compl),  32'd1);
    check("single_busy", 32'(busy),       32'd1);
    check("single_tag",  32'(tenc_tag),   32'h05);
    check("single_rid",  32'(tenc_rid),   32'h0100);
    check("single_code", 32'(compl_code), 32'(CPL_SC));
    check("single_tc",   32'(tenc_tc),    32'(exp_tc(0)));
    check("single_len",  32'(tenc_len),   32'(exp_len(0)));
    check("single_be",   32'(tenc_be),    32'(exp_be(0)));
    tick();
    settle();
    check("single_rc_after", 32'(req_compl), 32'd0);

    // ---------------- round robin from reset ----------------
    do_reset();
    rq_req            = 3'b111;
    tlp_encoder_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = k % 3;
      settle();
      check("rr_gnt", 32'(rq_gnt), 32'(1) << e);
      tick();
      settle();
      check("rr_rc",   32'(req_compl), 32'd1);
      check("rr_rid",  32'(tenc_rid),  32'(exp_rid(e)));
      check("rr_code", 32'(compl_code), 32'(exp_code(e)));
      check("rr_nognt", 32'(rq_gnt), 32'd0);
      tick();
    end

    // ---------------- backpressure (last winner 0) ----------------
    rq_req            = 3'b100;
    tlp_encoder_ready = 1'b0;
    settle();
    check("bp_gnt", 32'(rq_gnt), 32'h4);
    tick();
    rq_req  = 3'b011;
    tag_xor = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      settle();
      check("bp_rc_held",  32'(req_compl), 32'd1);
      check("bp_tag_held", 32'(tenc_tag),  32'(exp_tag(2)));
      check("bp_nognt",    32'(rq_gnt),    32'd0);
      tick();
    end
    tlp_encoder_ready = 1'b1;
    settle();
    check("bp_rc_c11", 32'(req_compl), 32'd1);
    tick();
    tag_xor = 8'h00;
    settle();
    check("bp_rc_idle",  32'(req_compl), 32'd0);
    check("bp_next_gnt", 32'(rq_gnt),    32'h1);
    tick();
    rq_req = '0;
    settle();
    check("bp_next_tag", 32'(tenc_tag), 32'(exp_tag(0)));
    tick();

    // ---------------- timeout (last winner 0) ----------------
    rq_req            = 3'b001;
    tlp_encoder_ready = 1'b0;
    settle();
    check("to_gnt", 32'(rq_gnt), 32'h1);
    tick();
    rq_req    = '0;
    to_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (!req_compl) break;
      to_cycles++;
      tick();
    end
    check("to_offer_cycles", 32'(to_cycles), 32'd16);
    check("to_drop1",        32'(drop_cnt),  32'd1);

    // ---------------- link down during offer ----------------
    rq_req = 3'b010;
    settle();
    check("ld_gnt", 32'(rq_gnt), 32'h2);
    tick();
    rq_req = 3'b111;
    lnk_up = 1'b0;
    settle();
    check("ld_rc_same_cycle", 32'(req_compl), 32'd1);
    tick();
    settle();
    check("ld_rc_dropped", 32'(req_compl), 32'd0);
    check("ld_drop2",      32'(drop_cnt),  32'd2);
    check("ld_nognt_a",    32'(rq_gnt),    32'd0);
    tick();
    settle();
    check("ld_nognt_b", 32'(rq_gnt), 32'd0);
    lnk_up = 1'b1;
    settle();
    check("ld_up_gnt", 32'(rq_gnt), 32'h4);
    tick();
    rq_req            = '0;
    tlp_encoder_ready = 1'b1;
    settle();
    check("ld_up_rid", 32'(tenc_rid), 32'(exp_rid(2)));
    tick();

    // ---------------- turn-off during offer (last winner 2) ----------------
    tlp_encoder_ready = 1'b0;
    rq_req            = 3'b001;
    settle();
    check("tof_gnt0", 32'(rq_gnt), 32'h1);
    tick();
    rq_req         = 3'b010;
    cfg_to_turnoff = 1'b1;
    settle();
    check("tof_nognt_a", 32'(rq_gnt), 32'd0);
    tick();
    cfg_to_turnoff = 1'b0;
    settle();
    check("tof_ok_early", 32'(cfg_to_turnoff_ok), 32'd0);
    check("tof_rc_held",  32'(req_compl),         32'd1);
    tick();
    tlp_encoder_ready = 1'b1;
    settle();
    check("tof_rc_accept", 32'(req_compl), 32'd1);
    check("tof_nognt_b",   32'(rq_gnt),    32'd0);
    tick();
    settle();
    check("tof_ok_pulse", 32'(cfg_to_turnoff_ok), 32'd1);
    check("tof_rc_idle",  32'(req_compl),         32'd0);
    check("tof_gnt1",     32'(rq_gnt),            32'h2);
    tick();
    rq_req = '0;
    settle();
    check("tof_ok_low", 32'(cfg_to_turnoff_ok), 32'd0);
    check("tof_rid1",   32'(tenc_rid),          32'(exp_rid(1)));
    tick();

    // ---------------- turn-off vs. request in IDLE, level held (last 1) ----
    rq_req         = 3'b001;
    cfg_to_turnoff = 1'b1;
    settle();
    check("tol_nognt_rise", 32'(rq_gnt), 32'd0);
    tick();
    settle();
    check("tol_nognt_pend", 32'(rq_gnt),            32'd0);
    check("tol_ok_wait",    32'(cfg_to_turnoff_ok), 32'd0);
    tick();
    settle();
    check("tol_ok_pulse", 32'(cfg_to_turnoff_ok), 32'd1);
    check("tol_gnt0",     32'(rq_gnt),            32'h1);
    tick();
    rq_req = '0;
    settle();
    check("tol_no_retrig", 32'(cfg_to_turnoff_ok), 32'd0);
    check("tol_rc",        32'(req_compl),         32'd1);
    tick();
    cfg_to_turnoff = 1'b0;

    // ---------------- async reset mid-offer (last 0) ----------------
    tlp_encoder_ready = 1'b0;
    rq_req            = 3'b001;
    settle();
    check("ar_gnt", 32'(rq_gnt), 32'h1);
    tick();
    rq_req = '0;
    settle();
    check("ar_rc_before",   32'(req_compl), 32'd1);
    check("ar_drop_before", 32'(drop_cnt),  32'd2);
    #1;
    reset = 1'b0;
    #1;
    check("ar_rc",   32'(req_compl), 32'd0);
    check("ar_busy", 32'(busy),      32'd0);
    check("ar_drop", 32'(drop_cnt),  32'd0);
    check("ar_rid",  32'(tenc_rid),  32'd0);
    tick();
    tick();
    reset             = 1'b1;
    rq_req            = 3'b111;
    tlp_encoder_ready = 1'b1;
    settle();
    check("ar_first_gnt", 32'(rq_gnt), 32'h1);
    tick();
    rq_req = '0;
    settle();
    check("ar_first_rid", 32'(tenc_rid), 32'(exp_rid(0)));
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
